// File: rtl/multi_track_icms.sv
// Multi-channel radar sweep controller: pulses each channel in turn, times its echo,
// and keeps per-channel range, threat and engage-permission flags.
module multi_track_icms #(
    parameter int CH        = 4,
    parameter int DW        = 32,
    parameter int PULSE_LEN = 50,
    parameter int TIMEOUT   = 1000,
    parameter int DPC       = 150
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  scan_en,
    input  logic                  mode,
    input  logic [CH-1:0]         radar_echo,
    input  logic [DW-1:0]         max_safe_distance,
    input  logic                  severe_weather,
    output logic [CH-1:0]         radar_pulse_trigger,
    output logic [$clog2(CH)-1:0] active_channel,
    output logic [CH*DW-1:0]      distance_to_target,
    output logic [CH-1:0]         threat_detected,
    output logic [CH-1:0]         safe_to_engage,
    output logic                  sweep_done,
    output logic [1:0]            state
);
    localparam int AW  = $clog2(CH);
    localparam int NW  = $clog2(TIMEOUT + 1);
    localparam int PCW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam int PW  = NW + 32 + DW;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_PULSE  = 2'b01;
    localparam logic [1:0] S_LISTEN = 2'b10;
    localparam logic [1:0] S_UPDATE = 2'b11;

    localparam logic [AW-1:0]  LAST_CH     = AW'(CH - 1);
    localparam logic [PCW-1:0] PULSE_LAST  = PCW'(PULSE_LEN - 1);
    localparam logic [NW-1:0]  LISTEN_LAST = NW'(TIMEOUT);

    logic [PCW-1:0]        pulse_cnt_r;
    logic [NW-1:0]         listen_cnt_r;
    logic                  echo_hit_r;
    logic [CH-1:0]         valid_r;
    logic [CH-1:0][DW-1:0] dist_r;

    logic [PW-1:0] range_full_s;
    logic [DW-1:0] range_s;
    logic          echo_s;
    logic          closer_s;
    logic          in_range_s;

    function automatic logic [CH-1:0] chan_onehot(input logic [AW-1:0] idx);
        logic [CH-1:0] oh;
        oh      = {CH{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

    assign distance_to_target = dist_r;

    // Range of the captured echo (full-width product, saturated to DW bits) and threat terms.
    always_comb begin
        range_full_s = PW'(listen_cnt_r) * PW'(DPC);
        if (|range_full_s[PW-1:DW]) begin
            range_s = {DW{1'b1}};
        end else begin
            range_s = range_full_s[DW-1:0];
        end
        echo_s     = radar_echo[active_channel];
        closer_s   = valid_r[active_channel] && (range_s < dist_r[active_channel]);
        in_range_s = (range_s <= max_safe_distance);
    end

    // Sweep sequencing, per-channel measurement results and engage permission.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state               <= S_IDLE;
            active_channel      <= {AW{1'b0}};
            radar_pulse_trigger <= {CH{1'b0}};
            pulse_cnt_r         <= {PCW{1'b0}};
            listen_cnt_r        <= {NW{1'b0}};
            echo_hit_r          <= 1'b0;
            valid_r             <= {CH{1'b0}};
            dist_r              <= '0;
            threat_detected     <= {CH{1'b0}};
            safe_to_engage      <= {CH{1'b0}};
            sweep_done          <= 1'b0;
        end else begin
            sweep_done     <= 1'b0;
            safe_to_engage <= threat_detected & ~{CH{severe_weather}};
            case (state)
                S_IDLE: begin
                    if (scan_en) begin
                        state               <= S_PULSE;
                        active_channel      <= {AW{1'b0}};
                        pulse_cnt_r         <= {PCW{1'b0}};
                        radar_pulse_trigger <= chan_onehot({AW{1'b0}});
                    end
                end
                S_PULSE: begin
                    if (pulse_cnt_r == PULSE_LAST) begin
                        state               <= S_LISTEN;
                        radar_pulse_trigger <= {CH{1'b0}};
                        listen_cnt_r        <= NW'(1);
                    end else begin
                        pulse_cnt_r <= pulse_cnt_r + PCW'(1);
                    end
                end
                S_LISTEN: begin
                    // An echo on the final listen cycle still counts as an echo.
                    if (echo_s) begin
                        echo_hit_r <= 1'b1;
                        state      <= S_UPDATE;
                    end else if (listen_cnt_r == LISTEN_LAST) begin
                        echo_hit_r <= 1'b0;
                        state      <= S_UPDATE;
                    end else begin
                        listen_cnt_r <= listen_cnt_r + NW'(1);
                    end
                end
                S_UPDATE: begin
                    if (echo_hit_r) begin
                        dist_r[active_channel]          <= range_s;
                        threat_detected[active_channel] <= closer_s && in_range_s;
                        valid_r[active_channel]         <= 1'b1;
                    end else begin
                        dist_r[active_channel]          <= {DW{1'b0}};
                        threat_detected[active_channel] <= 1'b0;
                        valid_r[active_channel]         <= 1'b0;
                    end
                    pulse_cnt_r <= {PCW{1'b0}};
                    if (!scan_en) begin
                        state          <= S_IDLE;
                        active_channel <= {AW{1'b0}};
                    end else if (active_channel != LAST_CH) begin
                        state               <= S_PULSE;
                        active_channel      <= active_channel + AW'(1);
                        radar_pulse_trigger <= chan_onehot(active_channel + AW'(1));
                    end else begin
                        sweep_done     <= 1'b1;
                        active_channel <= {AW{1'b0}};
                        if (mode) begin
                            state               <= S_PULSE;
                            radar_pulse_trigger <= chan_onehot({AW{1'b0}});
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
